// File: rtl/sensor_pio_pkg.sv
// Shared constants and helpers for the sensor PIO input port.
package sensor_pio_pkg;

    // Register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    // Edge selection encodings for the EDGE_TYPE parameter
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Event for one channel given its debounced level now and one cycle ago.
    function automatic logic edge_event(input logic        level,
                                        input logic        level_prev,
                                        input int unsigned edge_type);
        logic rise;
        logic fall;
        logic ev;
        rise = level & ~level_prev;
        fall = ~level & level_prev;
        case (edge_type)
            EDGE_RISING:  ev = rise;
            EDGE_FALLING: ev = fall;
            default:      ev = rise | fall;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/sensor_pio_debounce.sv
// One input channel: two-flop synchroniser, stability counter and the
// accepted level plus its one-cycle-delayed copy for edge detection.
module sensor_pio_debounce
    import sensor_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic level_o,
    output logic level_prev_o
);

    // A single-cycle debounce still needs a 1-bit counter to keep widths legal.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            d_q;
    logic            d_d;
    logic            d_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Count consecutive cycles the synchronised input disagrees with the accepted level.
    always_comb begin
        d_d   = d_q;
        cnt_d = cnt_q;
        if (s2_q == d_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            d_d   = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, accepted level and counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            d_q      <= 1'b0;
            d_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= in_i;
            s2_q     <= s1_q;
            d_q      <= d_d;
            d_prev_q <= d_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o      = d_q;
    assign level_prev_o = d_prev_q;

endmodule

// File: rtl/sensor_pio_in_irq.sv
// Avalon-MM slave input port: debounced sensor levels, per-channel edge
// capture with write-1-to-clear, and a maskable level interrupt.
module sensor_pio_in_irq
    import sensor_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_prev;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sensor_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk          (clk),
            .reset_n      (reset_n),
            .in_i         (in_port[i]),
            .level_o      (level[i]),
            .level_prev_o (level_prev[i])
        );
        assign events[i] = edge_event(level[i], level_prev[i], EDGE_TYPE);
    end

    // Upper write-data bits have no storage behind them.
    if (WIDTH < 32) begin : g_wdata_hi
        logic wdata_hi_unused;
        assign wdata_hi_unused = ^writedata[31:WIDTH];
    end

    // Mask write and edge-capture update; a new event overrides a same-cycle clear.
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            cap_d = cap_q & ~writedata[WIDTH-1:0];
        end
        cap_d = cap_d | events;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(level);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(cap_q);
            default:   readdata_d = '0;
        endcase
    end

    // Register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule
